// File: rtl/kb_event_arbiter_if.sv
// kb_event_arbiter_if: producer-side strobes and shared scancode event bus of the arbiter
interface kb_event_arbiter_if;
  logic       s0_valid;
  logic [9:0] s0_data;
  logic       s0_ready;
  logic       s1_valid;
  logic [9:0] s1_data;
  logic       s1_ready;
  logic       enable;
  logic       flush;
  logic       scan_received;
  logic [7:0] scancode;
  logic       extended;
  logic       released;
  logic       src;
  logic [1:0] ovf;
  logic       busy;
  modport master (
    output s0_valid, s0_data, s1_valid, s1_data, enable, flush,
    input  s0_ready, s1_ready, scan_received, scancode, extended, released, src, ovf, busy
  );
  modport slave (
    input  s0_valid, s0_data, s1_valid, s1_data, enable, flush,
    output s0_ready, s1_ready, scan_received, scancode, extended, released, src, ovf, busy
  );
endinterface

// File: rtl/kb_event_arbiter.sv
// kb_event_arbiter: round-robin arbiter sharing the scancode event bus between two FIFO-buffered producers
module kb_event_arbiter #(
  parameter int DEPTH = 4,
  parameter int GAP   = 16
) (
  input logic              clk,
  input logic              rst_n,
  kb_event_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(GAP + 1);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;
  state_t          r_state, w_next;
  logic [GW-1:0]   r_gcnt, w_gcnt;
  logic [1:0]      w_valid, w_ne, w_full, w_pop, w_push, w_ovf_set;
  logic [1:0][9:0] w_din, w_head;
  logic            w_take, w_gnt, r_last, r_src;
  logic [9:0]      r_out;
  logic [1:0]      r_ovf;
  assign w_valid = {bus.s1_valid, bus.s0_valid};
  assign w_din   = {bus.s1_data, bus.s0_data};
  assign w_take  = (r_state == S_IDLE) && bus.enable && |w_ne;
  // with both pending, alternate away from the previous winner
  assign w_gnt   = &w_ne ? ~r_last : w_ne[1];
  assign w_pop   = w_take ? (w_gnt ? 2'b10 : 2'b01) : 2'b00;
  for (genvar i = 0; i < 2; i++) begin : g_fifo
    logic [9:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [CW-1:0] r_cnt;
    assign w_ne[i]   = r_cnt != '0;
    assign w_full[i] = r_cnt == CW'(DEPTH);
    // fullness is judged before the pop, so a same-cycle pop still frees the slot
    assign w_push[i]    = w_valid[i] && (!w_full[i] || w_pop[i]) && !bus.flush;
    assign w_ovf_set[i] = w_valid[i] && w_full[i] && !w_pop[i] && !bus.flush;
    assign w_head[i]    = r_mem[r_rp];
    always_ff @(posedge clk)
      if (w_push[i]) r_mem[r_wp] <= w_din[i];
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
      end else if (bus.flush) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
      end else begin
        if (w_push[i]) r_wp <= r_wp + 1'b1;
        if (w_pop[i]) r_rp <= r_rp + 1'b1;
        r_cnt <= r_cnt + CW'(w_push[i]) - CW'(w_pop[i]);
      end
  end
  always_comb begin
    w_next = r_state;
    w_gcnt = r_gcnt;
    w_next = (r_state == S_IDLE) ? (w_take ? S_ISSUE : S_IDLE) :
             (r_state == S_ISSUE || r_gcnt != GW'(1)) ? S_GAP : S_IDLE;
    w_gcnt = (r_state == S_ISSUE) ? GW'(GAP) :
             (r_state == S_GAP) ? r_gcnt - 1'b1 : r_gcnt;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_gcnt  <= '0;
      r_out   <= '0;
      r_src   <= 1'b0;
      r_last  <= 1'b1;
      r_ovf   <= '0;
    end else begin
      r_state <= w_next;
      r_gcnt  <= w_gcnt;
      r_ovf   <= bus.flush ? 2'b00 : r_ovf | w_ovf_set;
      if (w_take) begin
        r_out  <= w_head[w_gnt];
        r_src  <= w_gnt;
        r_last <= w_gnt;
      end
    end
  assign bus.s0_ready      = ~w_full[0];
  assign bus.s1_ready      = ~w_full[1];
  assign bus.scan_received = r_state == S_ISSUE;
  assign bus.scancode      = r_out[7:0];
  assign bus.extended      = r_out[9];
  assign bus.released      = r_out[8];
  assign bus.src           = r_src;
  assign bus.ovf           = r_ovf;
  assign bus.busy          = |w_ne || r_state != S_IDLE;
endmodule

// File: doc/kb_event_arbiter.md
# kb_event_arbiter

Shares the single scancode event bus (`scan_received`, `scancode`, `extended`, `released`) feeding `kb_special_functions`, `keyboard_pressed_status` and `scancode_to_speccy` between two scancode producers: source 0 (MEGA65 matrix-to-scancode generator) and source 1 (PS/2 port receiver). Each source has its own small FIFO. Events are issued round-robin as single-cycle pulses, with an enforced minimum spacing so downstream keymap lookups complete between events. The block sits inside `ps2_keyb` between the producers and the translator chain.

## Interface
Parameters:
- `DEPTH`, 4: entries per source FIFO; power of two, ≥2.
- `GAP`, 16: idle cycles forced after each issued event; ≥1.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s0_valid`  in  1  source 0 event strobe; one event per cycle high.
- `s0_data`  in  10  source 0 event `{extended, released, scancode[7:0]}`.
- `s0_ready`  out  1  source 0 FIFO not full.
- `s1_valid`, `s1_data`, `s1_ready`: same as above, for source 1.
- `enable`  in  1  when low, no new event is issued; FIFOs keep accepting.
- `flush`  in  1  single-cycle: empty both FIFOs, clear `ovf`.
- `scan_received`  out  1  one-cycle event pulse.
- `scancode`  out  8  event scancode; held until the next issue.
- `extended`  out  1  event extended flag; held.
- `released`  out  1  event released flag; held.
- `src`  out  1  source of the last issued event; held.
- `ovf`  out  2  sticky per-source overflow flags (bit n = source n).
- `busy`  out  1  high when either FIFO is non-empty or state ≠ IDLE.

## Operation
- Reset values: FIFOs empty, state IDLE, `scan_received`=0, `scancode`=0, `extended`=0, `released`=0, `src`=0, `ovf`=0, `busy`=0, `s0_ready`=`s1_ready`=1, `last_grant`=1 (source 0 wins the first tie).
- Push: `sN_valid` high at a rising edge while FIFO N is not full → entry written.
  - FIFO full → event dropped, `ovf[N]` set.
  - `sN_ready` = ~full, combinational from FIFO count. Count width is `$clog2(DEPTH)+1`; pointers wrap modulo `DEPTH`.
- States:
  - IDLE: if `enable` and at least one FIFO is non-empty, grant a source and pop its head into the output registers. Go to ISSUE.
    - Grant rule: if only one FIFO is non-empty, grant it. If both are non-empty, grant the source ≠ `last_grant`. Then update `last_grant`.
  - ISSUE (1 cycle): `scan_received`=1. Load the gap counter with `GAP`. Go to GAP.
  - GAP: decrement the counter each cycle. When it reaches 0, go to IDLE (exactly `GAP` cycles in GAP).
- `scancode`, `extended`, `released` and `src` change only at the grant edge and are stable during and after the pulse.
- Flush: both FIFOs empty after that edge; `ovf` cleared.
  - Flush does not abort ISSUE or GAP; the current pulse and gap complete.
  - Flush has priority over pushes in the same cycle. Those pushes are dropped without setting `ovf`.
  - Output registers are not cleared by flush.
- `enable` low is sampled only in IDLE. Dropping it during ISSUE or GAP has no effect on the event in flight.
- Push and pop on the same FIFO in the same cycle are both honoured; the count is unchanged.
  - A push to a full FIFO in its pop cycle is accepted, because full is evaluated before the pop.
- `rst_n` low at any time, including mid-gap: immediate return to reset values. Queued events are lost.

## Timing
- Latency: `sN_valid` sampled high in cycle n with an empty FIFO and state IDLE → `scan_received` high in cycle n+2.
- Minimum spacing between `scan_received` pulses is `GAP`+2 cycles (ISSUE + `GAP` + IDLE). With default `GAP`=16, the spacing is 18 cycles.
- Sustained throughput is 1 event per `GAP`+2 cycles across both sources. Under contention the two sources alternate strictly.
- `busy` is registered-state derived; it deasserts the cycle after the last GAP cycle if both FIFOs are empty.

## Test plan
- Single event: `s0_data`=0x1C (ext=0, rel=0) one cycle → `scan_received` pulse 2 cycles later, `scancode`=0x1C, `src`=0, `busy` low 18 cycles after the push.
- Contention: 3 events pushed into each FIFO in the same cycles → issue order src 0,1,0,1,0,1; pulses exactly 18 cycles apart; data is in per-source FIFO order.
- Overflow: 5 back-to-back pushes to source 1 with `enable`=0 → `s1_ready` low after the 4th, `ovf`=2'b10, then `enable`=1 → exactly 4 events issued; `flush` → `ovf`=0.
- Flush mid-gap: push 2 events to source 0, pulse `flush` during the first GAP → first pulse completes, no second pulse, `busy` falls when the gap ends.
- Enable gating: event queued with `enable`=0 for 50 cycles → no pulse; `enable`=1 at cycle t → pulse at t+1 (sampled in IDLE at edge t).
- Async reset: assert `rst_n`=0 mid-GAP with 2 entries queued → all outputs return to reset values without a clock edge; no events are issued after release.
